// File: rtl/rob_multi_commit_pkg.sv
// Shared types for the reorder buffer: tag, pc/opcode info and entry layout.
package rob_multi_commit_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
    } pci_t;

    typedef struct packed {
        logic        valid;
        logic        rdy;
        logic [31:0] data;
        pci_t        pc_info;
    } rob_entry_t;

endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch / writeback / flush / commit bundle of the reorder buffer.
// Perf counter signals exist only when ROB_PERF_CNT_EN is defined.
interface rob_multi_commit_if
    import rob_multi_commit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = ROB_DEPTH,
    parameter int NUM_WB   = 3,
    parameter int COMMIT_W = 2
) ();
    localparam int TAG_W = $clog2(DEPTH);

    logic                               alloc_valid;
    pci_t                               alloc_pci;
    logic                               alloc_ready;
    logic [TAG_W-1:0]                   alloc_tag;
    logic [NUM_WB-1:0]                  wb_valid;
    logic [NUM_WB-1:0][TAG_W-1:0]       wb_tag;
    logic [NUM_WB-1:0][DATA_W-1:0]      wb_data;
    logic                               flush_valid;
    logic [TAG_W-1:0]                   flush_tag;
    logic [COMMIT_W-1:0]                commit_valid;
    logic [COMMIT_W-1:0][TAG_W-1:0]     commit_tag;
    logic [COMMIT_W-1:0][DATA_W-1:0]    commit_data;
    pci_t [COMMIT_W-1:0]                commit_pci;
    logic [TAG_W:0]                     count;
    logic                               empty;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                        perf_commits;
    logic [31:0]                        perf_full_stalls;

    modport master (
        output alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush_valid, flush_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data, commit_pci,
               count, empty, perf_commits, perf_full_stalls
    );
    modport slave (
        input  alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush_valid, flush_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data, commit_pci,
               count, empty, perf_commits, perf_full_stalls
    );
`else
    modport master (
        output alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush_valid, flush_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data, commit_pci,
               count, empty
    );
    modport slave (
        input  alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush_valid, flush_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data, commit_pci,
               count, empty
    );
`endif

endinterface

// File: rtl/rob_multi_commit_commit_sel.sv
// Retirement selector: head-relative ready vector -> contiguous commit mask and retire count.
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int NC_W     = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] i_rdy_vec,
    output logic [COMMIT_W-1:0] o_commit_valid,
    output logic [NC_W-1:0]     o_ncommit
);

    logic w_run;

    always_comb begin
        w_run          = 1'b1;
        o_commit_valid = '0;
        o_ncommit      = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_run             = w_run & i_rdy_vec[i];
            o_commit_valid[i] = w_run;
            if (w_run) o_ncommit = NC_W'(i + 1);
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order alloc, out-of-order writeback, in-order multi-commit, mispredict squash.
// Optional ROB_PERF_CNT_EN adds retired-entry and full-stall counters.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = ROB_DEPTH,
    parameter int NUM_WB   = 3,
    parameter int COMMIT_W = 2
) (
    input logic               clk,
    input logic               rst,
    rob_multi_commit_if.slave rob_if
);

    localparam int             TAG_W    = $clog2(DEPTH);
    localparam int             NC_W     = $clog2(COMMIT_W + 1);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rdy;
    logic [DATA_W-1:0] r_data [DEPTH];
    pci_t              r_pci  [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              w_alloc_ready;
    logic              w_fire;
    logic [TAG_W-1:0]  w_slot [COMMIT_W];
    logic [COMMIT_W-1:0] w_rdy_vec;
    logic [COMMIT_W-1:0] w_commit_valid;
    logic [NC_W-1:0]   w_ncommit;
    logic [TAG_W-1:0]  w_keep_len;
    logic [DEPTH-1:0]  w_squash;
    logic              w_wb_dup;

    assign w_alloc_ready = (r_count != FULL_CNT) && !rob_if.flush_valid;
    assign w_fire        = rob_if.alloc_valid && w_alloc_ready;
    assign w_keep_len    = rob_if.flush_tag - r_head;

    for (genvar i = 0; i < COMMIT_W; i++) begin : g_slot
        assign w_slot[i]              = r_head + TAG_W'(i);
        assign w_rdy_vec[i]           = r_valid[w_slot[i]] & r_rdy[w_slot[i]];
        assign rob_if.commit_tag[i]   = w_slot[i];
        assign rob_if.commit_data[i]  = r_data[w_slot[i]];
        assign rob_if.commit_pci[i]   = r_pci[w_slot[i]];
    end

    // Age is measured from head, so "younger than flush_tag" survives pointer wrap.
    for (genvar j = 0; j < DEPTH; j++) begin : g_squash
        assign w_squash[j] = rob_if.flush_valid &&
                             (TAG_W'(TAG_W'(j) - r_head) > w_keep_len);
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .NC_W     (NC_W)
    ) u_commit_sel (
        .i_rdy_vec      (w_rdy_vec),
        .o_commit_valid (w_commit_valid),
        .o_ncommit      (w_ncommit)
    );

    always_comb begin
        w_wb_dup = 1'b0;
        for (int a = 0; a < NUM_WB; a++) begin
            for (int b = a + 1; b < NUM_WB; b++) begin
                if (rob_if.wb_valid[a] && rob_if.wb_valid[b] &&
                    rob_if.wb_tag[a] == rob_if.wb_tag[b]) w_wb_dup = 1'b1;
            end
        end
    end

    a_wb_dup: assert property (@(posedge clk) disable iff (rst) !w_wb_dup);

    // Later assignments win: writeback, then commit clear, then squash, then alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_rdy   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                for (int c = 0; c < NUM_WB; c++) begin
                    if (rob_if.wb_valid[c] && rob_if.wb_tag[c] == TAG_W'(j) && r_valid[j]) begin
                        r_data[j] <= rob_if.wb_data[c];
                        r_rdy[j]  <= 1'b1;
                    end
                end
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (w_commit_valid[i]) begin
                    r_valid[w_slot[i]] <= 1'b0;
                    r_rdy[w_slot[i]]   <= 1'b0;
                end
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (w_squash[j]) begin
                    r_valid[j] <= 1'b0;
                    r_rdy[j]   <= 1'b0;
                end
            end
            if (w_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_rdy[r_tail]   <= 1'b0;
                r_pci[r_tail]   <= rob_if.alloc_pci;
            end
            r_head <= r_head + TAG_W'(w_ncommit);
            if (rob_if.flush_valid) begin
                r_tail  <= rob_if.flush_tag + 1'b1;
                r_count <= {1'b0, w_keep_len} + 1'b1 - (TAG_W + 1)'(w_ncommit);
            end else begin
                if (w_fire) r_tail <= r_tail + 1'b1;
                r_count <= r_count + (TAG_W + 1)'(w_fire) - (TAG_W + 1)'(w_ncommit);
            end
        end
    end

    assign rob_if.alloc_ready  = w_alloc_ready;
    assign rob_if.alloc_tag    = r_tail;
    assign rob_if.commit_valid = w_commit_valid;
    assign rob_if.count        = r_count;
    assign rob_if.empty        = (r_count == '0);

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_full_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_commits     <= '0;
            r_perf_full_stalls <= '0;
        end else begin
            r_perf_commits <= r_perf_commits + 32'(w_ncommit);
            if (rob_if.alloc_valid && !w_alloc_ready)
                r_perf_full_stalls <= r_perf_full_stalls + 32'd1;
        end
    end

    assign rob_if.perf_commits     = r_perf_commits;
    assign rob_if.perf_full_stalls = r_perf_full_stalls;
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized and directed scoreboard bench for rob_multi_commit against a queue-based ROB model.
module tb_rob_multi_commit;
    import rob_multi_commit_pkg::*;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 16;
    localparam int NUM_WB   = 3;
    localparam int COMMIT_W = 2;
    localparam int TW       = $clog2(DEPTH);

    logic clk;
    logic rst;

    rob_multi_commit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) bus ();

    rob_multi_commit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rob_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ne;
        int count;
        bit aready;
        int atag;
        bit empty;
    } cyc_t;

    typedef struct {
        int          tag;
        logic [31:0] data;
        pci_t        pci;
    } cm_t;

    cyc_t cyc_q[$];
    cm_t  cm_q[$];

    // Reference model: program-order list of live tags plus per-tag payload.
    int          rob_q[$];
    logic [31:0] m_data [DEPTH];
    pci_t        m_pci  [DEPTH];
    bit          m_rdy  [DEPTH];
    int          m_tail;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int n_ready();
        int n = 0;
        while (n < COMMIT_W && n < rob_q.size() && m_rdy[rob_q[n]]) n++;
        return n;
    endfunction

    function automatic bit in_rob(input int t);
        foreach (rob_q[q]) if (rob_q[q] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pos_of(input int t);
        foreach (rob_q[q]) if (rob_q[q] == t) return q;
        return -1;
    endfunction

    task automatic model_reset();
        rob_q.delete();
        for (int k = 0; k < DEPTH; k++) m_rdy[k] = 1'b0;
        m_tail = 0;
    endtask

    // One clock cycle: drive inputs, queue the expected view, advance the model at the edge.
    task automatic step(input bit av, input bit [2:0] wv, input int w0, input int w1, input int w2,
                        input bit fv, input int ft, input bit r);
        int          wt [3];
        logic [31:0] wd [3];
        pci_t        p;
        cyc_t        ec;
        cm_t         cm;
        int          ne;
        int          pos;
        bit          fire;
        wt[0] = w0; wt[1] = w1; wt[2] = w2;
        p.pc     = $urandom;
        p.opcode = 7'($urandom);
        for (int c = 0; c < NUM_WB; c++) wd[c] = $urandom;
        rst             = r;
        bus.alloc_valid = av;
        bus.alloc_pci   = p;
        bus.wb_valid    = wv;
        for (int c = 0; c < NUM_WB; c++) begin
            bus.wb_tag[c]  = TW'(wt[c]);
            bus.wb_data[c] = wd[c];
        end
        bus.flush_valid = fv;
        bus.flush_tag   = TW'(ft);
        ne        = n_ready();
        ec.ne     = ne;
        ec.count  = rob_q.size();
        ec.aready = (rob_q.size() < DEPTH) && !fv;
        ec.atag   = m_tail;
        ec.empty  = (rob_q.size() == 0);
        cyc_q.push_back(ec);
        for (int k = 0; k < ne; k++) begin
            cm.tag  = rob_q[k];
            cm.data = m_data[rob_q[k]];
            cm.pci  = m_pci[rob_q[k]];
            cm_q.push_back(cm);
        end
        fire = av && ec.aready;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int c = 0; c < NUM_WB; c++) begin
                if (wv[c] && in_rob(wt[c])) begin
                    m_data[wt[c]] = wd[c];
                    m_rdy[wt[c]]  = 1'b1;
                end
            end
            if (fv) begin
                pos = pos_of(ft);
                while (rob_q.size() > pos + 1) begin
                    m_rdy[rob_q[rob_q.size()-1]] = 1'b0;
                    void'(rob_q.pop_back());
                end
                m_tail = (ft + 1) % DEPTH;
            end
            for (int k = 0; k < ne; k++) begin
                m_rdy[rob_q[0]] = 1'b0;
                void'(rob_q.pop_front());
            end
            if (fire) begin
                rob_q.push_back(m_tail);
                m_pci[m_tail] = p;
                m_rdy[m_tail] = 1'b0;
                m_tail        = (m_tail + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic pick_wb(input int nmax, output bit [2:0] wv, output int w0, output int w1, output int w2);
        int cand[$];
        int t [3];
        int n;
        int k;
        wv = '0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        foreach (rob_q[q]) if (!m_rdy[rob_q[q]]) cand.push_back(rob_q[q]);
        n = $urandom_range(0, nmax);
        for (int c = 0; c < NUM_WB; c++) begin
            if (c < n && cand.size() > 0) begin
                k     = $urandom_range(0, cand.size() - 1);
                t[c]  = cand[k];
                cand.delete(k);
                wv[c] = 1'b1;
            end
        end
        w0 = t[0]; w1 = t[1]; w2 = t[2];
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic alloc_n(input int n);
        repeat (n) step(1'b1, 3'b000, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic drain();
        bit [2:0] wv;
        int w0, w1, w2;
        for (int it = 0; it < 100 && rob_q.size() > 0; it++) begin
            pick_wb(3, wv, w0, w1, w2);
            step(1'b0, wv, w0, w1, w2, 1'b0, 0, 1'b0);
        end
        idle(2);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        cyc_t ec;
        cm_t  cm;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                ec = cyc_q.pop_front();
                chk("commit_valid", 64'(bus.commit_valid), 64'((1 << ec.ne) - 1));
                chk("count", 64'(bus.count), 64'(ec.count));
                chk("empty", 64'(bus.empty), 64'(ec.empty));
                chk("alloc_ready", 64'(bus.alloc_ready), 64'(ec.aready));
                chk("alloc_tag", 64'(bus.alloc_tag), 64'(ec.atag));
                for (int i = 0; i < COMMIT_W; i++) begin
                    if (bus.commit_valid[i]) begin
                        if (cm_q.size() == 0) begin
                            chk("commit_unexpected", 64'(bus.commit_tag[i]), 64'hFFFF);
                        end else begin
                            cm = cm_q.pop_front();
                            chk("commit_tag", 64'(bus.commit_tag[i]), 64'(cm.tag));
                            chk("commit_data", 64'(bus.commit_data[i]), 64'(cm.data));
                            chk("commit_pci", 64'(bus.commit_pci[i]), 64'(cm.pci));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [2:0] wv;
        int w0, w1, w2;
        int ne, ft, lo;
        bit fv;
        rst             = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_pci   = '0;
        bus.wb_valid    = '0;
        bus.wb_tag      = '0;
        bus.wb_data     = '0;
        bus.flush_valid = 1'b0;
        bus.flush_tag   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Out-of-order completion holds retirement until the head is ready.
        alloc_n(3);
        step(1'b0, 3'b001, 1, 0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 3'b010, 0, 0, 0, 1'b0, 0, 1'b0);
        idle(1);
        step(1'b0, 3'b100, 0, 0, 2, 1'b0, 0, 1'b0);
        idle(3);

        // Full ROB: alloc reopens only the cycle after a commit.
        do_reset();
        alloc_n(16);
        step(1'b1, 3'b000, 0, 0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 3'b011, 0, 1, 0, 1'b0, 0, 1'b0);
        alloc_n(3);
        drain();

        // Steady stream long enough to wrap the tag space.
        do_reset();
        for (int k = 0; k < 48; k++) begin
            wv = '0; w0 = 0;
            if (rob_q.size() > 0 && !m_rdy[rob_q[rob_q.size()-1]]) begin
                wv = 3'b001;
                w0 = rob_q[rob_q.size()-1];
            end
            step(k < 40, wv, w0, 0, 0, 1'b0, 0, 1'b0);
        end
        drain();

        // Flush alongside alloc_valid; late writeback to a squashed tag.
        do_reset();
        alloc_n(8);
        step(1'b1, 3'b000, 0, 0, 0, 1'b1, 3, 1'b0);
        step(1'b0, 3'b001, 6, 0, 0, 1'b0, 0, 1'b0);
        alloc_n(2);
        drain();

        // Flush while the two oldest entries retire.
        do_reset();
        alloc_n(6);
        step(1'b0, 3'b011, 0, 1, 0, 1'b0, 0, 1'b0);
        step(1'b0, 3'b000, 0, 0, 0, 1'b1, 5, 1'b0);
        idle(1);
        drain();

        // Reset with pending entries and writebacks in flight.
        do_reset();
        alloc_n(10);
        step(1'b0, 3'b111, 0, 1, 4, 1'b0, 0, 1'b0);
        step(1'b1, 3'b011, 2, 3, 0, 1'b0, 0, 1'b1);
        idle(2);

        // Randomized mix of alloc, writeback and flush.
        for (int k = 0; k < 600; k++) begin
            pick_wb(3, wv, w0, w1, w2);
            ne = n_ready();
            fv = (rob_q.size() > 0) && ($urandom_range(0, 19) == 0);
            ft = 0;
            if (fv) begin
                lo = (ne > 0) ? ne - 1 : 0;
                ft = rob_q[$urandom_range(lo, rob_q.size() - 1)];
            end
            step($urandom_range(0, 3) != 0, wv, w0, w1, w2, fv, ft, 1'b0);
        end
        drain();

        @(negedge clk);
        #1;
        chk("commits_outstanding", 64'(cm_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
